// File: rtl/timer_sched_pkg.sv
// timer_sched_pkg: shared time-base encoding, channel state enum and default sizes
// for the timer_sched block.
package timer_sched_pkg;

  localparam int unsigned NUM_CH_DEF   = 4;
  localparam int unsigned PERIOD_W_DEF = 16;

  typedef enum logic [1:0] {
    UNIT_US   = 2'd0,
    UNIT_MS   = 2'd1,
    UNIT_SEC  = 2'd2,
    UNIT_RSVD = 2'd3
  } unit_e;

  typedef enum logic [1:0] {
    CH_IDLE = 2'd0,
    CH_RUN  = 2'd1,
    CH_DONE = 2'd2
  } ch_state_e;

  // Pick the tick pulse matching a channel's time base; reserved unit never ticks.
  function automatic logic tick_sel(input unit_e unit, input logic us,
                                    input logic ms, input logic sec);
    logic t;
    t = 1'b0;
    case (unit)
      UNIT_US:  t = us;
      UNIT_MS:  t = ms;
      UNIT_SEC: t = sec;
      default:  t = 1'b0;
    endcase
    return t;
  endfunction

endpackage

// File: rtl/timer_sched_rr_arb.sv
// timer_sched_rr_arb: combinational round-robin arbiter. The search starts at
// ptr_i and wraps; the first requesting channel found gets a one-hot grant.
module timer_sched_rr_arb
  import timer_sched_pkg::*;
#(
  parameter int unsigned NUM_CH = NUM_CH_DEF
) (
  input  logic [NUM_CH-1:0]         req_i,
  input  logic [$clog2(NUM_CH)-1:0] ptr_i,
  output logic [NUM_CH-1:0]         gnt_o
);

  localparam int unsigned CH_W = $clog2(NUM_CH);

  int unsigned     idx;
  logic [CH_W-1:0] sel;
  logic            found;

  // Scan channels in priority order ptr_i, ptr_i+1, ... and grant the first request.
  always_comb begin
    gnt_o = '0;
    found = 1'b0;
    idx   = 0;
    sel   = '0;
    for (int unsigned k = 0; k < NUM_CH; k++) begin
      idx = 32'(ptr_i) + k;
      if (idx >= NUM_CH) idx = idx - NUM_CH;
      sel = CH_W'(idx);
      if (!found && req_i[sel]) begin
        gnt_o[sel] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/timer_sched.sv
// timer_sched: NUM_CH programmable timers driven by us/ms/sec tick pulses. Each
// channel expires after its period, raises a pending bit, and pending channels are
// presented one at a time on a valid/ready event port via round-robin arbitration.
// Optional build macro TIMER_SCHED_OVERRUN_EN enables sticky evt_overrun flags;
// without it evt_overrun is tied low and missed expiries are dropped.
module timer_sched
  import timer_sched_pkg::*;
#(
  parameter int unsigned NUM_CH   = NUM_CH_DEF,
  parameter int unsigned PERIOD_W = PERIOD_W_DEF
) (
  input  logic                      clk_200,
  input  logic                      resetb,
  input  logic                      us_tick,
  input  logic                      ms_tick,
  input  logic                      sec_tick,
  input  logic                      cfg_valid,
  output logic                      cfg_ready,
  input  logic [$clog2(NUM_CH)-1:0] cfg_ch,
  input  logic [1:0]                cfg_unit,
  input  logic [PERIOD_W-1:0]       cfg_period,
  input  logic                      cfg_mode,
  input  logic                      cfg_en,
  output logic                      evt_valid,
  input  logic                      evt_ready,
  output logic [$clog2(NUM_CH)-1:0] evt_ch,
  output logic [NUM_CH-1:0]         ch_active,
  output logic [NUM_CH-1:0]         evt_overrun
);

  localparam int unsigned CH_W = $clog2(NUM_CH);

  ch_state_e           state_q  [NUM_CH];
  ch_state_e           state_d  [NUM_CH];
  logic [PERIOD_W-1:0] cnt_q    [NUM_CH];
  logic [PERIOD_W-1:0] cnt_d    [NUM_CH];
  logic [PERIOD_W-1:0] period_q [NUM_CH];
  logic [PERIOD_W-1:0] period_d [NUM_CH];
  unit_e               unit_q   [NUM_CH];
  unit_e               unit_d   [NUM_CH];
  logic [NUM_CH-1:0]   mode_q, mode_d;
  logic [NUM_CH-1:0]   pend_q, pend_d;

  logic [NUM_CH-1:0]   tick_vec, exp_vec, hs_vec, acc_vec, req_vec, gnt_vec;

  logic                cfg_ready_q, cfg_ready_d;
  logic                evt_valid_q, evt_valid_d;
  logic [CH_W-1:0]     evt_ch_q, evt_ch_d;
  logic [CH_W-1:0]     ptr_q, ptr_d;
  logic [CH_W-1:0]     gnt_idx;

  logic                accept, start_ok, hs, load;

  assign accept   = cfg_valid & cfg_ready_q;
  assign start_ok = cfg_en && (cfg_period != '0) && (cfg_unit != UNIT_RSVD);
  assign hs       = evt_valid_q & evt_ready;
  // The event slot is refilled when empty or when the current event is taken.
  assign load     = !evt_valid_q || hs;

  // Per-channel decode of ticks, expiries, handshake hits and cfg hits.
  always_comb begin
    tick_vec = '0;
    exp_vec  = '0;
    hs_vec   = '0;
    acc_vec  = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      tick_vec[i] = (state_q[i] == CH_RUN) &&
                    tick_sel(unit_q[i], us_tick, ms_tick, sec_tick);
      exp_vec[i]  = tick_vec[i] && (cnt_q[i] == PERIOD_W'(1));
      hs_vec[i]   = hs && (evt_ch_q == CH_W'(i));
      acc_vec[i]  = accept && (cfg_ch == CH_W'(i));
    end
  end

  // Channel FSM next state; a cfg accept is applied last so it overrides an expiry.
  always_comb begin
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      state_d[i]  = state_q[i];
      cnt_d[i]    = cnt_q[i];
      period_d[i] = period_q[i];
      unit_d[i]   = unit_q[i];
    end
    mode_d = mode_q;
    pend_d = pend_q;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (hs_vec[i]) begin
        pend_d[i] = 1'b0;
        if (state_q[i] == CH_DONE) state_d[i] = CH_IDLE;
      end
      if (tick_vec[i]) begin
        if (exp_vec[i]) begin
          pend_d[i] = 1'b1;
          if (mode_q[i]) cnt_d[i] = period_q[i];
          else           state_d[i] = CH_DONE;
        end else begin
          cnt_d[i] = cnt_q[i] - PERIOD_W'(1);
        end
      end
      if (acc_vec[i]) begin
        pend_d[i] = 1'b0;
        if (start_ok) begin
          state_d[i]  = CH_RUN;
          cnt_d[i]    = cfg_period;
          period_d[i] = cfg_period;
          unit_d[i]   = unit_e'(cfg_unit);
          mode_d[i]   = cfg_mode;
        end else begin
          state_d[i]  = CH_IDLE;
        end
      end
    end
  end

  // Channel state registers.
  always_ff @(posedge clk_200 or negedge resetb) begin
    if (!resetb) begin
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        state_q[i]  <= CH_IDLE;
        cnt_q[i]    <= '0;
        period_q[i] <= '0;
        unit_q[i]   <= UNIT_US;
      end
      mode_q <= '0;
      pend_q <= '0;
    end else begin
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        state_q[i]  <= state_d[i];
        cnt_q[i]    <= cnt_d[i];
        period_q[i] <= period_d[i];
        unit_q[i]   <= unit_d[i];
      end
      mode_q <= mode_d;
      pend_q <= pend_d;
    end
  end

  // The channel being handshaked this cycle must not be granted again.
  assign req_vec = pend_q & ~hs_vec;

  timer_sched_rr_arb #(
    .NUM_CH (NUM_CH)
  ) u_arb (
    .req_i (req_vec),
    .ptr_i (ptr_q),
    .gnt_o (gnt_vec)
  );

  // One-hot grant to channel index.
  always_comb begin
    gnt_idx = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (gnt_vec[i]) gnt_idx = CH_W'(i);
    end
  end

  // Event slot and round-robin pointer next state; held while waiting for evt_ready.
  always_comb begin
    evt_valid_d = evt_valid_q;
    evt_ch_d    = evt_ch_q;
    ptr_d       = ptr_q;
    cfg_ready_d = !accept;
    if (load) begin
      evt_valid_d = |gnt_vec;
      if (|gnt_vec) begin
        evt_ch_d = gnt_idx;
        ptr_d    = (gnt_idx == CH_W'(NUM_CH - 1)) ? '0 : gnt_idx + CH_W'(1);
      end
    end
  end

  // Event, pointer and cfg_ready registers.
  always_ff @(posedge clk_200 or negedge resetb) begin
    if (!resetb) begin
      evt_valid_q <= 1'b0;
      evt_ch_q    <= '0;
      ptr_q       <= '0;
      cfg_ready_q <= 1'b0;
    end else begin
      evt_valid_q <= evt_valid_d;
      evt_ch_q    <= evt_ch_d;
      ptr_q       <= ptr_d;
      cfg_ready_q <= cfg_ready_d;
    end
  end

`ifdef TIMER_SCHED_OVERRUN_EN
  logic [NUM_CH-1:0] ovr_q, ovr_d;

  // An expiry that finds pending still set (not drained or overridden this cycle) is sticky until reconfigured.
  always_comb begin
    ovr_d = (ovr_q | (exp_vec & pend_q & ~hs_vec & ~acc_vec)) & ~acc_vec;
  end

  // Overrun flag register.
  always_ff @(posedge clk_200 or negedge resetb) begin
    if (!resetb) ovr_q <= '0;
    else         ovr_q <= ovr_d;
  end

  assign evt_overrun = ovr_q;
`else
  assign evt_overrun = '0;
`endif

  // Channel activity view.
  always_comb begin
    ch_active = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      ch_active[i] = (state_q[i] != CH_IDLE);
    end
  end

  assign cfg_ready = cfg_ready_q;
  assign evt_valid = evt_valid_q;
  assign evt_ch    = evt_ch_q;

endmodule

// File: tb/tb_timer_sched.sv
// tb_timer_sched: directed bench for timer_sched with a reference model feeding an
// event scoreboard (expected channel and arrival cycle) checked on each handshake.
module tb_timer_sched;

  logic        clk_200 = 1'b0;
  logic        resetb;
  logic        us_tick, ms_tick, sec_tick;
  logic        cfg_valid, cfg_ready;
  logic [1:0]  cfg_ch, cfg_unit;
  logic [15:0] cfg_period;
  logic        cfg_mode, cfg_en;
  logic        evt_valid, evt_ready;
  logic [1:0]  evt_ch;
  logic [3:0]  ch_active, evt_overrun;

  timer_sched #(
    .NUM_CH   (4),
    .PERIOD_W (16)
  ) dut (
    .clk_200     (clk_200),
    .resetb      (resetb),
    .us_tick     (us_tick),
    .ms_tick     (ms_tick),
    .sec_tick    (sec_tick),
    .cfg_valid   (cfg_valid),
    .cfg_ready   (cfg_ready),
    .cfg_ch      (cfg_ch),
    .cfg_unit    (cfg_unit),
    .cfg_period  (cfg_period),
    .cfg_mode    (cfg_mode),
    .cfg_en      (cfg_en),
    .evt_valid   (evt_valid),
    .evt_ready   (evt_ready),
    .evt_ch      (evt_ch),
    .ch_active   (ch_active),
    .evt_overrun (evt_overrun)
  );

  always #5 clk_200 = ~clk_200;

  int cyc = 0;
  always @(posedge clk_200) cyc <= cyc + 1;

  int n_vec = 0;
  int n_err = 0;

  typedef struct { int ch; int cyc; } exp_t;
  exp_t q[$];

  // Reference model state
  int         m_unit [4];
  int         m_per  [4];
  int         m_cnt  [4];
  logic [3:0] m_run, m_mode, m_pend, m_ovr;
  int         m_ptr;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk_200);
    #1;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      m_unit[i] = 0; m_per[i] = 0; m_cnt[i] = 0;
    end
    m_run = '0; m_mode = '0; m_pend = '0; m_ovr = '0; m_ptr = 0;
  endtask

  task automatic model_cfg(input int ch, input int unit, input int per, input bit mode, input bit en);
    m_pend[ch] = 1'b0;
    m_ovr[ch]  = 1'b0;
    if (en && per != 0 && unit != 3) begin
      m_run[ch] = 1'b1; m_unit[ch] = unit; m_per[ch] = per; m_cnt[ch] = per; m_mode[ch] = mode;
    end else begin
      m_run[ch] = 1'b0;
    end
  endtask

  // Tick driven in cycle k; timed events appear at k+2, k+3, ... in round-robin order.
  task automatic model_tick(input int kind, input int k, input bit timed);
    logic [3:0] hit;
    int slot, c, start, last;
    hit = '0;
    for (int i = 0; i < 4; i++) begin
      if (m_run[i] && m_unit[i] == kind) begin
        m_cnt[i]--;
        if (m_cnt[i] == 0) begin
`ifdef TIMER_SCHED_OVERRUN_EN
          if (m_pend[i]) m_ovr[i] = 1'b1;
`endif
          if (!m_pend[i]) begin
            hit[i] = 1'b1;
            m_pend[i] = 1'b1;
          end
          if (m_mode[i]) m_cnt[i] = m_per[i];
          else           m_run[i] = 1'b0;
        end
      end
    end
    slot = 0; start = m_ptr; last = 0;
    for (int i = 0; i < 4; i++) begin
      c = (start + i) % 4;
      if (hit[c]) begin
        q.push_back('{c, timed ? k + 2 + slot : -1});
        slot++;
        last = c;
      end
    end
    if (slot > 0) m_ptr = (last + 1) % 4;
  endtask

  // One-cycle tick pulse of the given kind (0=us,1=ms,2=sec), then idle cycles.
  task automatic pulse(input int kind);
    case (kind)
      0:       us_tick  = 1'b1;
      1:       ms_tick  = 1'b1;
      default: sec_tick = 1'b1;
    endcase
    model_tick(kind, cyc, evt_ready);
    step(1);
    us_tick = 1'b0; ms_tick = 1'b0; sec_tick = 1'b0;
    step(8);
  endtask

  task automatic cfg(input int ch, input int unit, input int per, input bit mode,
                     input bit en, input bit with_tick);
    int n;
    n = 0;
    while (!cfg_ready && n < 20) begin
      step(1);
      n++;
    end
    chk("cfg_ready_wait", cfg_ready, 1);
    cfg_valid = 1'b1; cfg_ch = ch[1:0]; cfg_unit = unit[1:0];
    cfg_period = per[15:0]; cfg_mode = mode; cfg_en = en;
    if (with_tick) us_tick = 1'b1;
    step(1);
    cfg_valid = 1'b0; us_tick = 1'b0;
    chk("cfg_ready_drop", cfg_ready, 0);
    model_cfg(ch, unit, per, mode, en);
    if (with_tick) model_tick(0, cyc - 1, 1'b1);
  endtask

  // Scoreboard: every handshake must match the oldest expected event.
  always @(negedge clk_200) begin
    exp_t e;
    if (resetb && evt_valid && evt_ready) begin
      if (q.size() == 0) begin
        chk("evt_spurious", {31'd0, evt_valid}, 0);
      end else begin
        e = q.pop_front();
        chk("evt_ch", {30'd0, evt_ch}, e.ch);
        if (e.cyc >= 0) chk("evt_cycle", cyc, e.cyc);
        m_pend[e.ch] = 1'b0;
      end
    end
  end

  initial begin
    int n;
    resetb = 1'b0; us_tick = 1'b0; ms_tick = 1'b0; sec_tick = 1'b0;
    cfg_valid = 1'b0; cfg_ch = '0; cfg_unit = '0; cfg_period = '0;
    cfg_mode = 1'b0; cfg_en = 1'b0; evt_ready = 1'b1;
    model_reset();

    // Reset values
    step(3);
    chk("rst_cfg_ready", cfg_ready, 0);
    chk("rst_evt_valid", evt_valid, 0);
    chk("rst_evt_ch", evt_ch, 0);
    chk("rst_ch_active", ch_active, 0);
    chk("rst_overrun", evt_overrun, 0);
    resetb = 1'b1;
    #1;
    chk("cfg_ready_pre_edge", cfg_ready, 0);
    step(1);
    chk("cfg_ready_post_edge", cfg_ready, 1);

    // All four channels, us period 1: back-to-back round-robin 0,1,2,3
    for (int c = 0; c < 4; c++) cfg(c, 0, 1, 1'b1, 1'b1, 1'b0);
    chk("rr_active", ch_active, 4'hF);
    pulse(0);
    pulse(0);
    for (int c = 0; c < 4; c++) cfg(c, 0, 1, 1'b1, 1'b0, 1'b0);
    chk("rr_stopped", ch_active, 0);

    // ch0 us period 3 periodic: events after 3rd, 6th, 9th tick
    cfg(0, 0, 3, 1'b1, 1'b1, 1'b0);
    for (int t = 0; t < 9; t++) pulse(0);
    cfg(0, 0, 3, 1'b1, 1'b0, 1'b0);

    // ch1 ms period 2 one-shot; us ticks must not count
    cfg(1, 1, 2, 1'b0, 1'b1, 1'b0);
    chk("os_active", {28'd0, ch_active}, 32'h2);
    pulse(1);
    pulse(0);
    pulse(2);
    pulse(1);
    chk("os_idle_after_hs", {31'd0, ch_active[1]}, 0);
    pulse(1);

    // ch2 us period 1 periodic with consumer stalled: single held event, overrun
    evt_ready = 1'b0;
    cfg(2, 0, 1, 1'b1, 1'b1, 1'b0);
    for (int t = 0; t < 5; t++) pulse(0);
    chk("stall_valid", evt_valid, 1);
    chk("stall_ch", evt_ch, 2);
    chk("stall_overrun", evt_overrun, m_ovr);
    chk("stall_queue", q.size(), 1);
    cfg(2, 0, 1, 1'b1, 1'b0, 1'b0);
    chk("stall_hold_valid", evt_valid, 1);
    chk("stall_hold_ch", evt_ch, 2);
    chk("overrun_cleared", evt_overrun, m_ovr);
    evt_ready = 1'b1;
    step(2);
    chk("stall_drained", evt_valid, 0);
    chk("stall_ch2_idle", ch_active, 0);

    // cfg stop in same cycle as expiry: no event, channel idle
    cfg(0, 0, 2, 1'b1, 1'b1, 1'b0);
    pulse(0);
    cfg(0, 0, 2, 1'b1, 1'b0, 1'b1);
    step(8);
    chk("override_idle", ch_active, 0);
    chk("override_no_evt", evt_valid, 0);
    cfg(0, 0, 0, 1'b1, 1'b1, 1'b0);
    chk("period0_idle", ch_active, 0);
    cfg(0, 3, 5, 1'b1, 1'b1, 1'b0);
    chk("unit3_idle", ch_active, 0);
    pulse(0);
    pulse(0);

    // Reset while an event is presented on ch2
    evt_ready = 1'b0;
    cfg(2, 0, 1, 1'b1, 1'b1, 1'b0);
    pulse(0);
    chk("pre_rst_valid", evt_valid, 1);
    chk("pre_rst_ch", evt_ch, 2);
    resetb = 1'b0;
    #1;
    chk("arst_evt_valid", evt_valid, 0);
    chk("arst_evt_ch", evt_ch, 0);
    chk("arst_cfg_ready", cfg_ready, 0);
    chk("arst_ch_active", ch_active, 0);
    chk("arst_overrun", evt_overrun, 0);
    q.delete();
    model_reset();
    evt_ready = 1'b1;
    step(2);
    resetb = 1'b1;
    step(1);
    chk("rerst_cfg_ready", cfg_ready, 1);
    for (int c = 0; c < 4; c++) cfg(c, 0, 1, 1'b1, 1'b1, 1'b0);
    pulse(0);

    n = 0;
    while (q.size() != 0 && n < 50) begin
      step(1);
      n++;
    end
    chk("queue_drained", q.size(), 0);
    chk("final_overrun", evt_overrun, m_ovr);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/timer_sched.md
TIMER_SCHED -- requirements
Module: timer_sched

Interface
REQ-001 SHALL have parameter NUM_CH, default 4, meaning number of timer channels (2..8).
REQ-002 SHALL have parameter PERIOD_W, default 16, meaning period/counter width.
REQ-003 SHALL have port clk_200  input  1  system clock, 200 MHz.
REQ-004 SHALL have port resetb  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port us_tick  input  1  one-cycle pulse, once per microsecond.
REQ-006 SHALL have port ms_tick  input  1  one-cycle pulse, once per millisecond.
REQ-007 SHALL have port sec_tick  input  1  one-cycle pulse, once per second.
REQ-008 SHALL have port cfg_valid  input  1  configuration write request.
REQ-009 SHALL have port cfg_ready  output  1  configuration write can be accepted.
REQ-010 SHALL have port cfg_ch  input  $clog2(NUM_CH)  target channel.
REQ-011 SHALL have port cfg_unit  input  2  time base: 0=us, 1=ms, 2=sec, 3=reserved.
REQ-012 SHALL have port cfg_period  input  PERIOD_W  period in units.
REQ-013 SHALL have port cfg_mode  input  1  0=one-shot, 1=periodic.
REQ-014 SHALL have port cfg_en  input  1  1=start channel, 0=stop channel.
REQ-015 SHALL have port evt_valid  output  1  expiry event presented.
REQ-016 SHALL have port evt_ready  input  1  consumer accepts event.
REQ-017 SHALL have port evt_ch  output  $clog2(NUM_CH)  channel of the presented event.
REQ-018 SHALL have port ch_active  output  NUM_CH  per-channel state is not IDLE.
REQ-019 SHALL have port evt_overrun  output  NUM_CH  sticky per-channel missed-event flag.

Function
REQ-020 SHALL give each channel a state machine with states IDLE, RUN and DONE, plus a count register and a pending bit.
REQ-021 SHALL accept a cfg write in any cycle where cfg_valid and cfg_ready are both high; cfg_ready SHALL be 0 for the single cycle after an accept and 1 otherwise.
REQ-022 SHALL, on an accept with cfg_en=1, a period other than 0 and a unit other than 3, load count=cfg_period, clear pending, clear evt_overrun[ch] and enter RUN; any other accept SHALL clear pending and enter IDLE.
REQ-023 SHALL, in RUN, decrement count by 1 on each cycle in which the selected tick is high.
REQ-024 SHALL treat a tick seen with count==1 as an expiry: set pending; if periodic, reload count=period and stay in RUN; if one-shot, go to DONE.
REQ-025 SHALL make a period of P units produce its first expiry on the P-th selected tick after the accept.
REQ-026 SHALL let a cfg accept to a channel override an expiry on that channel in the same cycle, so that no pending bit is set.
REQ-027 SHALL select among pending channels with round-robin arbitration, starting the search just after the last granted channel; after reset the search SHALL start at channel 0.
REQ-028 SHALL register evt_valid and evt_ch: the grant SHALL appear the cycle after pending is visible, so an event is 2 cycles after the expiry tick.
REQ-029 SHALL hold evt_valid and evt_ch stable until evt_ready is high, even if a cfg write hits that channel meanwhile.
REQ-030 SHALL, on handshake, clear that channel's pending bit (a one-shot then goes DONE->IDLE); a new grant MAY be presented in the next cycle, giving back-to-back events.
REQ-031 SHALL count an expiry that occurs while pending is still set as an overrun, with no second event queued.

Reset
REQ-032 SHALL, while resetb is low, force all channels to IDLE with count=0 and pending=0, evt_valid=0, evt_ch=0, the round-robin pointer=0, cfg_ready=0, ch_active=0 and evt_overrun=0.
REQ-033 SHALL drive cfg_ready=1 from the first clk_200 edge after resetb deasserts.

Configuration
REQ-034 SHALL, with TIMER_SCHED_OVERRUN_EN defined, set evt_overrun[ch] sticky on an overrun and clear it only on a cfg accept to that channel.
REQ-035 SHALL, without TIMER_SCHED_OVERRUN_EN, tie evt_overrun to 0 and drop overruns silently.

Structure
REQ-036 SHALL place the unit encoding, the channel state enum and the default NUM_CH/PERIOD_W constants in package timer_sched_pkg.
REQ-037 SHALL implement the round-robin grant as sub-module timer_sched_rr_arb (request vector and pointer in, one-hot grant out).

Verification
REQ-038 SHALL cover: ch0 set to us, period 3, periodic, evt_ready=1 -> evt_valid with evt_ch=0 two cycles after the 3rd, 6th and 9th us_tick.
REQ-039 SHALL cover: ch1 set to ms, period 2, one-shot -> exactly one event after the 2nd ms_tick, and ch_active[1] returns to 0 after the handshake.
REQ-040 SHALL cover: ch0..ch3 all set to us, period 1, evt_ready=1 -> events in order 0,1,2,3,0,... with no gaps between handshakes.
REQ-041 SHALL cover: ch2 set to us, period 1, periodic, evt_ready=0 for 5 us -> a single event, evt_ch held at 2, and evt_overrun[2]=1 with the macro or 0 without it.
REQ-042 SHALL cover: cfg write to ch0 with cfg_en=0 in the same cycle as its expiry tick -> no event and ch0 goes IDLE; period 0 or unit 3 -> channel stays IDLE.
REQ-043 SHALL cover: resetb asserted while evt_valid=1 -> all outputs take their REQ-032 values immediately, and round-robin restarts at channel 0.
